// File: rtl/seq_pkg.sv
// Shared types and constants for the 9-bit core's instruction sequencer.
// Instruction layout: ir[0] selects the instruction type, and ir[4:1] holds the opcode.
// classify() reduces an instruction to the handful of cases the sequencer treats differently.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      HALT  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CLS_PLAIN  = 3'd0,
      CLS_MEM    = 3'd1,
      CLS_JUMP   = 3'd2,
      CLS_BRANCH = 3'd3,
      CLS_HALT   = 3'd4
   } op_class_t;

   localparam logic [3:0] OP_LOAD  = 4'b0001;
   localparam logic [3:0] OP_STORE = 4'b0010;
   localparam logic [3:0] OP_JUMP  = 4'b1000;
   localparam logic [3:0] OP_BEQ   = 4'b1001;
   localparam logic [3:0] OP_BLT   = 4'b1010;
   localparam logic [3:0] OP_BGT   = 4'b1011;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic ITYPE_PUT = 1'b1;

   // Put-type instructions never affect control flow or memory, whatever their opcode field.
   function automatic op_class_t classify(input logic [4:0] ir_lo);
      op_class_t cls;
      cls = CLS_PLAIN;
      if (ir_lo[0] != ITYPE_PUT) begin
         case (ir_lo[4:1])
            OP_LOAD, OP_STORE:      cls = CLS_MEM;
            OP_JUMP:                cls = CLS_JUMP;
            OP_BEQ, OP_BLT, OP_BGT: cls = CLS_BRANCH;
            OP_HALT:                cls = CLS_HALT;
            default:                cls = CLS_PLAIN;
         endcase
      end
      return cls;
   endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// Cycle and retired-instruction counters for the sequencer.
// Latency: counts update on the clock edge that ends each counted cycle.
// No backpressure: both counters wrap silently at 2**32.
module seq_perf_cnt (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        busy,
   input  logic        ins_evt,
   output logic [31:0] cyc_cnt,
   output logic [31:0] ins_cnt
);

   // Both counters clear on reset or on an accepted start; otherwise they count qualifying cycles.
   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         cyc_cnt <= '0;
         ins_cnt <= '0;
      end else begin
         if (busy)    cyc_cnt <= cyc_cnt + 32'd1;
         if (ins_evt) ins_cnt <= ins_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: it owns the PC and the IR, gates decoder commits, and resolves jumps, branches and HALT.
// Latency: a plain, jump or branch instruction takes 2 cycles; a load or store takes 3+N cycles for an ack N cycles after mem_req rises.
// Backpressure: the core holds in MEM with mem_req high until mem_ack arrives; INSTR_SEQUENCER_PERF_EN builds the counters.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [8:0]      rom_data,
   input  logic            alu_cond,
   input  logic [PC_W-1:0] branch_target,
   input  logic            mem_ack,
   output logic [PC_W-1:0] rom_addr,
   output logic [8:0]      ir,
   output logic            commit,
   output logic            mem_req,
   output logic            busy,
   output logic            done,
   output logic [31:0]     cyc_cnt,
   output logic [31:0]     ins_cnt
);

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [8:0]      ir_q, ir_nxt;
   logic            mem_req_q, mem_req_nxt;
   logic            commit_c;
   op_class_t       cls;
   logic [PC_W-1:0] pc_inc;

   assign cls    = classify(ir_q[4:0]);
   assign pc_inc = pc + PC_W'(1);

   // State, PC, IR and memory-request registers. Reset drops any outstanding request immediately.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         pc        <= START_PC;
         ir_q      <= '0;
         mem_req_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         ir_q      <= ir_nxt;
         mem_req_q <= mem_req_nxt;
      end
   end

   // Next-state logic and the commit strobe. Commit only occurs in EXEC or on the ack cycle, and both are followed by FETCH.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      ir_nxt      = ir_q;
      mem_req_nxt = mem_req_q;
      commit_c    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
               pc_nxt    = START_PC;
            end
         end
         FETCH: begin
            ir_nxt    = rom_data;
            state_nxt = EXEC;
         end
         EXEC: begin
            case (cls)
               CLS_JUMP: begin
                  commit_c  = 1'b1;
                  pc_nxt    = branch_target;
                  state_nxt = FETCH;
               end
               CLS_BRANCH: begin
                  commit_c  = 1'b1;
                  pc_nxt    = alu_cond ? branch_target : pc_inc;
                  state_nxt = FETCH;
               end
               CLS_MEM: begin
                  mem_req_nxt = 1'b1;
                  state_nxt   = MEM;
               end
               CLS_HALT: begin
                  state_nxt = HALT;
               end
               default: begin
                  commit_c  = 1'b1;
                  pc_nxt    = pc_inc;
                  state_nxt = FETCH;
               end
            endcase
         end
         MEM: begin
            if (mem_ack) begin
               commit_c    = 1'b1;
               mem_req_nxt = 1'b0;
               pc_nxt      = pc_inc;
               state_nxt   = FETCH;
            end
         end
         HALT: begin
            if (start) begin
               state_nxt = FETCH;
               pc_nxt    = START_PC;
            end
         end
         default: begin
            state_nxt   = IDLE;
            mem_req_nxt = 1'b0;
         end
      endcase
   end

   assign rom_addr = pc;
   assign ir       = ir_q;
   assign commit   = commit_c;
   assign mem_req  = mem_req_q;
   assign busy     = (state == FETCH) || (state == EXEC) || (state == MEM);
   assign done     = (state == HALT);

`ifdef INSTR_SEQUENCER_PERF_EN
   logic clr;
   logic ins_evt;

   // HALT retires without a commit, so the EXEC->HALT step is counted explicitly.
   assign clr     = start && ((state == IDLE) || (state == HALT));
   assign ins_evt = commit_c || ((state == EXEC) && (cls == CLS_HALT));

   seq_perf_cnt u_perf (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .busy    (busy),
      .ins_evt (ins_evt),
      .cyc_cnt (cyc_cnt),
      .ins_cnt (ins_cnt)
   );
`else
   assign cyc_cnt = '0;
   assign ins_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, self-checking bench for instr_sequencer. It uses a 10-bit-PC instance and a 4-bit-PC instance for the wrap case.
// The expected commits (PC and IR) are queued as instructions are stepped, and a negedge monitor pops and compares them.
module tb_instr_sequencer;
   import seq_pkg::*;

   typedef struct packed {
      logic [9:0] pc;
      logic [8:0] ins;
   } exp_t;

`ifdef INSTR_SEQUENCER_PERF_EN
   localparam int EXP_CYC = 6;
   localparam int EXP_INS = 3;
`else
   localparam int EXP_CYC = 0;
   localparam int EXP_INS = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n, start, alu_cond, mem_ack;
   logic [9:0]  branch_target, rom_addr;
   logic [8:0]  rom_data, ir;
   logic        commit, mem_req, busy, done;
   logic [31:0] cyc_cnt, ins_cnt;

   logic        start_b;
   logic [3:0]  tgt_b, rom_addr_b;
   logic [8:0]  rom_data_b, ir_b;
   logic        commit_b, mem_req_b, busy_b, done_b;
   logic [31:0] cyc_b, ins_b;

   logic [8:0]  rom   [1024];
   logic [8:0]  rom_b [16];

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic prev_commit = 1'b0;

   always #5 clk = ~clk;

   assign rom_data   = rom[rom_addr];
   assign rom_data_b = rom_b[rom_addr_b];

   instr_sequencer #(.PC_W(10)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rom_data(rom_data),
      .alu_cond(alu_cond), .branch_target(branch_target), .mem_ack(mem_ack),
      .rom_addr(rom_addr), .ir(ir), .commit(commit), .mem_req(mem_req),
      .busy(busy), .done(done), .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
   );

   instr_sequencer #(.PC_W(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .rom_data(rom_data_b),
      .alu_cond(alu_cond), .branch_target(tgt_b), .mem_ack(mem_ack),
      .rom_addr(rom_addr_b), .ir(ir_b), .commit(commit_b), .mem_req(mem_req_b),
      .busy(busy_b), .done(done_b), .cyc_cnt(cyc_b), .ins_cnt(ins_b)
   );

   function automatic logic [8:0] mk(input logic it, input logic [3:0] op);
      return {4'b0000, op, it};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Scoreboard: every commit must match the next queued (pc, instruction), and commits never occur back to back.
   always @(negedge clk) begin
      exp_t e;
      if (commit === 1'b1) begin
         chk("commit_b2b", {31'd0, prev_commit}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_commit", {22'd0, rom_addr}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("sb_pc", {22'd0, rom_addr}, {22'd0, e.pc});
            chk("sb_ir", {23'd0, ir}, {23'd0, e.ins});
         end
      end
      prev_commit <= (commit === 1'b1);
   end

   // Non-memory instruction: the FETCH and EXEC cycles. On entry the bench is just after the edge that started FETCH.
   task automatic plain_step(input string tag, input logic [9:0] pc_exp,
                             input logic [9:0] tgt, input logic cond);
      smp;
      chk({tag, "_fetch_pc"}, {22'd0, rom_addr}, {22'd0, pc_exp});
      chk({tag, "_fetch_commit"}, {31'd0, commit}, 32'd0);
      tick;
      branch_target = tgt;
      alu_cond      = cond;
      sb.push_back('{pc: pc_exp, ins: rom[pc_exp]});
      smp;
      chk({tag, "_exec_commit"}, {31'd0, commit}, 32'd1);
      tick;
   endtask

   // Load or store, acked n cycles after mem_req rises. A start pulse in MEM must be ignored.
   task automatic mem_step(input string tag, input logic [9:0] pc_exp, input int n);
      smp;
      chk({tag, "_fetch_pc"}, {22'd0, rom_addr}, {22'd0, pc_exp});
      tick;
      smp;
      chk({tag, "_exec_commit"}, {31'd0, commit}, 32'd0);
      chk({tag, "_exec_req"}, {31'd0, mem_req}, 32'd0);
      tick;
      for (int k = 0; k <= n; k++) begin
         start   = (k == 0);
         mem_ack = (k == n);
         if (k == n) sb.push_back('{pc: pc_exp, ins: rom[pc_exp]});
         smp;
         chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
         chk({tag, "_mem_commit"}, {31'd0, commit}, {31'd0, (k == n)});
         tick;
         start   = 1'b0;
         mem_ack = 1'b0;
      end
      chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_next_pc"}, {22'd0, rom_addr}, {22'd0, pc_exp + 10'd1});
   endtask

   // HALT instruction: no commit in EXEC, then done with PC held. A stray mem_ack must be ignored.
   task automatic halt_step(input string tag, input logic [9:0] pc_exp);
      smp;
      chk({tag, "_fetch_pc"}, {22'd0, rom_addr}, {22'd0, pc_exp});
      tick;
      smp;
      chk({tag, "_exec_commit"}, {31'd0, commit}, 32'd0);
      chk({tag, "_exec_done"}, {31'd0, done}, 32'd0);
      tick;
      mem_ack = 1'b1;
      smp;
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_stray_ack"}, {31'd0, commit}, 32'd0);
      chk({tag, "_pc_hold"}, {22'd0, rom_addr}, {22'd0, pc_exp});
      tick;
      mem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; alu_cond = 1'b0; mem_ack = 1'b0;
      branch_target = '0; start_b = 1'b0; tgt_b = '0;
      for (int i = 0; i < 1024; i++) rom[i] = '0;
      for (int i = 0; i < 16; i++) rom_b[i] = '0;

      repeat (3) tick;
      chk("rst_pc", {22'd0, rom_addr}, 32'd0);
      chk("rst_ir", {23'd0, ir}, 32'd0);
      chk("rst_commit", {31'd0, commit}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cyc", cyc_cnt, 32'd0);
      chk("rst_ins", ins_cnt, 32'd0);
      reset_n = 1'b1;

      // 4-bit PC: jump to 15, and the plain op there wraps the PC to 0.
      rom_b[0]  = mk(1'b0, OP_JUMP);
      rom_b[15] = mk(1'b0, 4'b0011);
      tick; start_b = 1'b1;
      tick; start_b = 1'b0;
      smp;  chk("b_fetch0", {28'd0, rom_addr_b}, 32'd0);
      tick; tgt_b = 4'd15;
      smp;  chk("b_jump_commit", {31'd0, commit_b}, 32'd1);
      tick;
      smp;  chk("b_at15", {28'd0, rom_addr_b}, 32'd15);
      tick;
      smp;  chk("b_add_commit", {31'd0, commit_b}, 32'd1);
            chk("b_add_ir", {23'd0, ir_b}, {23'd0, mk(1'b0, 4'b0011)});
      tick;
      smp;  chk("b_wrap_pc", {28'd0, rom_addr_b}, 32'd0);
            chk("b_busy", {31'd0, busy_b}, 32'd1);
      chk("idle_no_start", {31'd0, busy}, 32'd0);

      // Program 1: add, xor (put-type), HALT. The start pulse is in cycle 0.
      rom[0] = mk(1'b0, 4'b0011);
      rom[1] = mk(1'b1, 4'b0101);
      rom[2] = mk(1'b0, OP_HALT);
      sb.push_back('{pc: 10'd0, ins: rom[0]});
      sb.push_back('{pc: 10'd1, ins: rom[1]});
      for (int c = 0; c < 8; c++) begin
         tick;
         start = (c == 0);
         smp;
         chk($sformatf("p1_commit_c%0d", c), {31'd0, commit}, {31'd0, (c == 2 || c == 4)});
         chk($sformatf("p1_busy_c%0d", c), {31'd0, busy}, {31'd0, (c >= 1 && c <= 6)});
         chk($sformatf("p1_done_c%0d", c), {31'd0, done}, {31'd0, (c == 7)});
      end
      start = 1'b0;
      chk("p1_final_pc", {22'd0, rom_addr}, 32'd2);
      chk("p1_final_ir", {23'd0, ir}, {23'd0, mk(1'b0, OP_HALT)});
      chk("p1_cyc_cnt", cyc_cnt, EXP_CYC);
      chk("p1_ins_cnt", ins_cnt, EXP_INS);

      // Program 2: jumps, branches, memory ops and the wrap at 1023, then a restart from HALT.
      rom[0]    = mk(1'b0, OP_JUMP);
      rom[5]    = mk(1'b0, OP_JUMP);
      rom[40]   = mk(1'b1, OP_JUMP);
      rom[41]   = mk(1'b0, OP_JUMP);
      rom[7]    = mk(1'b0, OP_BEQ);
      rom[20]   = mk(1'b0, OP_JUMP);
      rom[8]    = mk(1'b0, OP_BLT);
      rom[3]    = mk(1'b0, OP_LOAD);
      rom[4]    = mk(1'b0, OP_STORE);
      rom[1023] = mk(1'b0, 4'b0011);
      rom[9]    = mk(1'b0, OP_BGT);
      rom[10]   = mk(1'b0, OP_HALT);
      tick; start = 1'b1;
      tick; start = 1'b0;
      chk("restart_cyc_clr", cyc_cnt, 32'd0);
      plain_step("j0",      10'd0,    10'd5,  1'b0);
      plain_step("j5",      10'd5,    10'd40, 1'b0);
      plain_step("put_jop", 10'd40,   10'd99, 1'b1);
      plain_step("j41",     10'd41,   10'd7,  1'b0);
      plain_step("beq_t",   10'd7,    10'd20, 1'b1);
      plain_step("j20",     10'd20,   10'd7,  1'b0);
      plain_step("beq_nt",  10'd7,    10'd20, 1'b0);
      plain_step("blt_t",   10'd8,    10'd3,  1'b1);
      mem_step("load", 10'd3, 4);
      mem_step("store", 10'd4, 0);
      plain_step("j5b",     10'd5,    10'd1023, 1'b0);
      plain_step("wrap",    10'd1023, 10'd0,  1'b0);
      plain_step("j0b",     10'd0,    10'd9,  1'b0);
      plain_step("bgt_nt",  10'd9,    10'd3,  1'b0);
      halt_step("halt", 10'd10);

      // Reset while in MEM: the request drops at that edge, and a late ack produces no commit.
      start = 1'b1;
      tick; start = 1'b0;
      plain_step("j0c", 10'd0, 10'd3, 1'b0);
      smp;  chk("mr_fetch_pc", {22'd0, rom_addr}, 32'd3);
      tick;
      tick;
      smp;  chk("mr_in_mem", {31'd0, mem_req}, 32'd1);
      tick; reset_n = 1'b0;
      smp;  chk("mr_req_before_edge", {31'd0, mem_req}, 32'd1);
      tick; reset_n = 1'b1; mem_ack = 1'b1;
      smp;  chk("mr_req_dropped", {31'd0, mem_req}, 32'd0);
            chk("mr_late_ack", {31'd0, commit}, 32'd0);
            chk("mr_idle", {31'd0, busy}, 32'd0);
            chk("mr_pc", {22'd0, rom_addr}, 32'd0);
      tick; mem_ack = 1'b0;
      smp;  chk("mr_stays_idle", {31'd0, busy}, 32'd0);

      chk("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
